// File: rtl/arena_pkg.sv
// Shared arena definitions: cell codes, grid geometry, colours and the cell address packing.
package arena_pkg;

    localparam int CELL_SHIFT = 3;
    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int ADDR_W     = 13;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_P1    = 2'd1,
        CELL_WALL  = 2'd2,
        CELL_P2    = 2'd3
    } cell_t;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } flash_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK    = 24'h000000;
    localparam rgb_t RGB_P1_HEAD  = 24'hFFFF00;
    localparam rgb_t RGB_P2_HEAD  = 24'h00FFFF;
    localparam rgb_t RGB_P1_TRAIL = 24'h7F7F00;
    localparam rgb_t RGB_WALL     = 24'h606060;
    localparam rgb_t RGB_P2_TRAIL = 24'h007F7F;
    localparam rgb_t RGB_GRID     = 24'h181818;

    // Row-major cell address with a 128-cell row pitch, shared with the RAM and player blocks.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [5:0] cell_y, input logic [6:0] cell_x);
        return {cell_y, cell_x};
    endfunction

endpackage

// File: rtl/arena_flash_ctrl.sv
// Frame-start detector plus the PLAY/OVER state machine that drives the game-over flash phase.
module arena_flash_ctrl
    import arena_pkg::*;
#(
    parameter int FLASH_FRAMES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic       fim_de_jogo,
    output logic       frame_tick,
    output logic       flash_phase
);

    localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_FRAMES - 1);

    flash_state_t  state;
    logic [CW-1:0] count;
    logic          prev_origin;
    logic          at_origin;

    assign at_origin = (next_x == '0) && (next_y == '0);

    // The counter advances on the registered tick, so a phase flip lands one cycle after the pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_origin <= 1'b0;
            frame_tick  <= 1'b0;
            state       <= PLAY;
            count       <= '0;
            flash_phase <= 1'b0;
        end else begin
            prev_origin <= at_origin;
            frame_tick  <= at_origin && !prev_origin;
            case (state)
                PLAY: begin
                    count       <= '0;
                    flash_phase <= 1'b0;
                    if (fim_de_jogo)
                        state <= OVER;
                end
                OVER: begin
                    if (!fim_de_jogo) begin
                        state       <= PLAY;
                        count       <= '0;
                        flash_phase <= 1'b0;
                    end else if (frame_tick) begin
                        if (count == LAST) begin
                            count       <= '0;
                            flash_phase <= ~flash_phase;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: rtl/arena_renderer.sv
// Two-stage arena pixel renderer: cell fetch, then colour mapping with head overlays and flash.
// Optional build macro ARENA_GRID_LINES_EN draws dim grid lines on empty cells.
module arena_renderer
    import arena_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int FLASH_FRAMES = 15
) (
    input  logic              VGA_CLK,
    input  logic              reset,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    input  logic              fim_de_jogo,
    input  logic [9:0]        p1_x,
    input  logic [9:0]        p1_y,
    input  logic [9:0]        p2_x,
    input  logic [9:0]        p2_y,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [7:0]        OUT_R,
    output logic [7:0]        OUT_G,
    output logic [7:0]        OUT_B,
    output logic              frame_tick
);

    // Widened to 11 bits so a head near x=1023 cannot wrap its right edge.
    function automatic logic head_hit(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] hx, input logic [9:0] hy);
        return ({1'b0, px} >= {1'b0, hx}) && ({1'b0, px} < ({1'b0, hx} + 11'd8)) &&
               ({1'b0, py} >= {1'b0, hy}) && ({1'b0, py} < ({1'b0, hy} + 11'd8));
    endfunction

    logic [6:0] cell_x;
    logic [6:0] cell_y;
    logic       visible_now;
    logic       flash_phase;

    logic       s0_valid;
    logic       s0_visible;
    logic       s0_p1_hit;
    logic       s0_p2_hit;
`ifdef ARENA_GRID_LINES_EN
    logic       s0_grid;
`endif

    rgb_t       cell_rgb;
    rgb_t       pix_rgb;
    rgb_t       pix_q;

    assign cell_x = 7'(next_x >> CELL_SHIFT);
    assign cell_y = 7'(next_y >> CELL_SHIFT);
    assign visible_now = (next_x < 10'(H_ACTIVE)) && (next_y < 10'(V_ACTIVE)) &&
                         (cell_x < 7'(GRID_W)) && (cell_y < 7'(GRID_H));

    arena_flash_ctrl #(
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
        .clk        (VGA_CLK),
        .reset      (reset),
        .next_x     (next_x),
        .next_y     (next_y),
        .fim_de_jogo(fim_de_jogo),
        .frame_tick (frame_tick),
        .flash_phase(flash_phase)
    );

    // Stage 0: issue the RAM read and capture everything the colour stage needs alongside rd_data.
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            rd_addr    <= '0;
            s0_valid   <= 1'b0;
            s0_visible <= 1'b0;
            s0_p1_hit  <= 1'b0;
            s0_p2_hit  <= 1'b0;
`ifdef ARENA_GRID_LINES_EN
            s0_grid    <= 1'b0;
`endif
        end else begin
            rd_addr    <= pack_addr(cell_y[5:0], cell_x);
            s0_valid   <= 1'b1;
            s0_visible <= visible_now;
            s0_p1_hit  <= head_hit(next_x, next_y, p1_x, p1_y);
            s0_p2_hit  <= head_hit(next_x, next_y, p2_x, p2_y);
`ifdef ARENA_GRID_LINES_EN
            s0_grid    <= (next_x[CELL_SHIFT-1:0] == '0) || (next_y[CELL_SHIFT-1:0] == '0);
`endif
        end
    end

    // Heads sit above the flash inversion; off-screen pixels stay black regardless.
    always_comb begin
        cell_rgb = RGB_BLACK;
        case (cell_t'(rd_data))
            CELL_P1:   cell_rgb = RGB_P1_TRAIL;
            CELL_WALL: cell_rgb = RGB_WALL;
            CELL_P2:   cell_rgb = RGB_P2_TRAIL;
            default:   cell_rgb = RGB_BLACK;
        endcase
`ifdef ARENA_GRID_LINES_EN
        if ((cell_t'(rd_data) == CELL_EMPTY) && s0_grid)
            cell_rgb = RGB_GRID;
`endif
        if (flash_phase)
            cell_rgb = rgb_t'(~cell_rgb);

        if (!s0_visible)
            pix_rgb = RGB_BLACK;
        else if (s0_p1_hit)
            pix_rgb = RGB_P1_HEAD;
        else if (s0_p2_hit)
            pix_rgb = RGB_P2_HEAD;
        else
            pix_rgb = cell_rgb;
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset)
            pix_q <= RGB_BLACK;
        else
            pix_q <= s0_valid ? pix_rgb : RGB_BLACK;
    end

    assign OUT_R = pix_q.r;
    assign OUT_G = pix_q.g;
    assign OUT_B = pix_q.b;

endmodule

// File: tb/tb_arena_renderer.sv
// Self-checking bench for arena_renderer: directed vectors, flash/frame sequences and a random stream.
module tb_arena_renderer;

    localparam int PARK = 900;
`ifdef ARENA_GRID_LINES_EN
    localparam bit GRID_EN = 1'b1;
`else
    localparam bit GRID_EN = 1'b0;
`endif

    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic [9:0]  next_x, next_y;
    logic        fim_de_jogo;
    logic [9:0]  p1_x, p1_y, p2_x, p2_y;
    logic [12:0] rd_addr;
    logic [1:0]  rd_data;
    logic [7:0]  OUT_R, OUT_G, OUT_B;
    logic        frame_tick;
    logic [23:0] dut_rgb;

    logic [1:0]  mem [8192];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 VGA_CLK = ~VGA_CLK;

    // Arena RAM: the address register lives in the DUT, so data follows rd_addr within the cycle.
    assign rd_data = mem[rd_addr];
    assign dut_rgb = {OUT_R, OUT_G, OUT_B};

    arena_renderer #(
        .FLASH_FRAMES(2)
    ) dut (
        .VGA_CLK    (VGA_CLK),
        .reset      (reset),
        .next_x     (next_x),
        .next_y     (next_y),
        .fim_de_jogo(fim_de_jogo),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p2_x       (p2_x),
        .p2_y       (p2_y),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .OUT_R      (OUT_R),
        .OUT_G      (OUT_G),
        .OUT_B      (OUT_B),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int          x, y;
        int          p1x, p1y, p2x, p2y;
        int          cell_idx;
        logic [1:0]  code;
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        int x, y, p1x, p1y, p2x, p2y;
    } pix_t;

    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic apply_stimulus(input int x, input int y, input int p1x, input int p1y,
                                  input int p2x, input int p2y);
        next_x = 10'(x);
        next_y = 10'(y);
        p1_x   = 10'(p1x);
        p1_y   = 10'(p1y);
        p2_x   = 10'(p2x);
        p2_y   = 10'(p2y);
    endtask

    task automatic check_output(input string name, input logic [23:0] actual, input logic [23:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference colour straight from the rules: bounds, head rectangles, then the stored cell code.
    function automatic logic [23:0] model_pixel(input pix_t p);
        int code;
        if (p.x >= 640 || p.y >= 480) return 24'h000000;
        if (p.x >= p.p1x && p.x < p.p1x + 8 && p.y >= p.p1y && p.y < p.p1y + 8) return 24'hFFFF00;
        if (p.x >= p.p2x && p.x < p.p2x + 8 && p.y >= p.p2y && p.y < p.p2y + 8) return 24'h00FFFF;
        code = int'(mem[(p.y / 8) * 128 + (p.x / 8)]);
        case (code)
            1:       return 24'h7F7F00;
            2:       return 24'h606060;
            3:       return 24'h007F7F;
            default: return (GRID_EN && (p.x % 8 == 0 || p.y % 8 == 0)) ? 24'h181818 : 24'h000000;
        endcase
    endfunction

    function automatic int near(input int v);
        int r;
        r = v - int'($urandom_range(0, 9));
        return (r < 0) ? 0 : r;
    endfunction

    initial begin
        vec_t vecs[15];
        pix_t hist[$];
        pix_t cur;
        int   ticks;

        for (int i = 0; i < 8192; i++) mem[i] = 2'd0;
        reset = 1'b0;
        fim_de_jogo = 1'b0;
        apply_stimulus(100, 0, PARK, PARK, PARK, PARK);

        // Reset held for three cycles
        repeat (3) step();
        check_output("reset_rgb", dut_rgb, 24'h000000);
        check_output("reset_addr", 24'(rd_addr), 24'd0);
        check_output("reset_tick", 24'(frame_tick), 24'd0);

        mem[130] = 2'd1;
        reset = 1'b1;
        apply_stimulus(17, 9, PARK, PARK, PARK, PARK);
        step();
        check_output("first_addr", 24'(rd_addr), 24'd130);
        step();
        check_output("first_rgb", dut_rgb, 24'h7F7F00);

        for (int x = 16; x < 24; x++) begin
            apply_stimulus(x, 9, PARK, PARK, PARK, PARK);
            step();
            step();
            check_output($sformatf("sweep_x%0d", x), dut_rgb, 24'h7F7F00);
        end

        vecs[0]  = '{17, 9, PARK, PARK, PARK, PARK, 130, 2'd1, 24'h7F7F00};
        vecs[1]  = '{22, 14, PARK, PARK, PARK, PARK, 130, 2'd2, 24'h606060};
        vecs[2]  = '{220, 244, 216, 240, PARK, PARK, 3867, 2'd1, 24'hFFFF00};
        vecs[3]  = '{220, 244, 216, 240, 216, 240, 3867, 2'd1, 24'hFFFF00};
        vecs[4]  = '{220, 244, PARK, PARK, 216, 240, 3867, 2'd1, 24'h00FFFF};
        vecs[5]  = '{223, 247, 216, 240, PARK, PARK, 3867, 2'd1, 24'hFFFF00};
        vecs[6]  = '{224, 244, 216, 240, PARK, PARK, 3868, 2'd1, 24'h7F7F00};
        vecs[7]  = '{215, 240, 216, 240, PARK, PARK, 3866, 2'd2, 24'h606060};
        vecs[8]  = '{700, 9, PARK, PARK, PARK, PARK, 215, 2'd2, 24'h000000};
        vecs[9]  = '{100, 500, PARK, PARK, PARK, PARK, 7948, 2'd2, 24'h000000};
        vecs[10] = '{639, 479, PARK, PARK, PARK, PARK, 7631, 2'd3, 24'h007F7F};
        vecs[11] = '{20, 9, PARK, PARK, PARK, PARK, 130, 2'd0, 24'h000000};
        vecs[12] = '{8, 3, PARK, PARK, PARK, PARK, 1, 2'd0, GRID_EN ? 24'h181818 : 24'h000000};
        vecs[13] = '{9, 3, PARK, PARK, PARK, PARK, 1, 2'd0, 24'h000000};
        vecs[14] = '{216, 248, 216, 240, PARK, PARK, 3995, 2'd1, 24'h7F7F00};

        foreach (vecs[i]) begin
            mem[vecs[i].cell_idx] = vecs[i].code;
            apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].p1x, vecs[i].p1y, vecs[i].p2x, vecs[i].p2y);
            step();
            step();
            check_output($sformatf("vec%0d", i), dut_rgb, vecs[i].exp);
        end

        // One pulse for a held origin after the last pixel of a frame
        apply_stimulus(639, 479, PARK, PARK, PARK, PARK);
        step();
        apply_stimulus(0, 0, PARK, PARK, PARK, PARK);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) check_output("tick_first", 24'(frame_tick), 24'd1);
            if (frame_tick) ticks++;
        end
        check_output("tick_count", 24'(ticks), 24'd1);

        // Game-over flash with a two-frame half-period on a wall cell
        mem[130] = 2'd2;
        mem[12 * 128 + 12] = 2'd0;
        fim_de_jogo = 1'b1;
        apply_stimulus(17, 9, PARK, PARK, PARK, PARK);
        step();
        apply_stimulus(5, 5, PARK, PARK, PARK, PARK);
        step();
        apply_stimulus(0, 0, PARK, PARK, PARK, PARK);
        step();
        apply_stimulus(17, 9, PARK, PARK, PARK, PARK);
        step();
        step();
        check_output("flash_frame1", dut_rgb, 24'h606060);
        apply_stimulus(0, 0, PARK, PARK, PARK, PARK);
        step();
        apply_stimulus(17, 9, PARK, PARK, PARK, PARK);
        step();
        step();
        check_output("flash_wall_inv", dut_rgb, 24'h9F9F9F);
        apply_stimulus(220, 244, 216, 240, PARK, PARK);
        step();
        step();
        check_output("flash_head", dut_rgb, 24'hFFFF00);
        apply_stimulus(100, 100, PARK, PARK, PARK, PARK);
        step();
        step();
        check_output("flash_empty_inv", dut_rgb, 24'hFFFFFF);
        apply_stimulus(700, 9, PARK, PARK, PARK, PARK);
        step();
        step();
        check_output("flash_offscreen", dut_rgb, 24'h000000);
        fim_de_jogo = 1'b0;
        apply_stimulus(17, 9, PARK, PARK, PARK, PARK);
        repeat (3) step();
        check_output("flash_exit", dut_rgb, 24'h606060);

        // Back-to-back random pixels against the reference model
        for (int i = 0; i < 8192; i++) mem[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            cur.x   = int'($urandom_range(0, 719));
            cur.y   = int'($urandom_range(0, 539));
            cur.p1x = ($urandom_range(0, 2) == 0) ? near(cur.x) : int'($urandom_range(0, 1023));
            cur.p1y = ($urandom_range(0, 2) == 0) ? near(cur.y) : int'($urandom_range(0, 1023));
            cur.p2x = ($urandom_range(0, 2) == 0) ? near(cur.x) : int'($urandom_range(0, 1023));
            cur.p2y = ($urandom_range(0, 2) == 0) ? near(cur.y) : int'($urandom_range(0, 1023));
            apply_stimulus(cur.x, cur.y, cur.p1x, cur.p1y, cur.p2x, cur.p2y);
            hist.push_back(cur);
            step();
            if (hist.size() == 2)
                check_output($sformatf("rand%0d", i), dut_rgb, model_pixel(hist.pop_front()));
        end

        // Reset asserted mid-frame, then the pipeline refills
        mem[130] = 2'd1;
        apply_stimulus(17, 9, PARK, PARK, PARK, PARK);
        step();
        step();
        check_output("pre_reset_rgb", dut_rgb, 24'h7F7F00);
        reset = 1'b0;
        step();
        check_output("mid_reset_rgb", dut_rgb, 24'h000000);
        check_output("mid_reset_addr", 24'(rd_addr), 24'd0);
        reset = 1'b1;
        step();
        check_output("refill_rgb1", dut_rgb, 24'h000000);
        step();
        check_output("refill_rgb2", dut_rgb, 24'h7F7F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
